// File: rtl/isw_and_seq_ctrl.sv
// Sequential 3-share ISW masked AND: nine partial products on one shared AND/XOR path, refresh randoms fetched by handshake.
// Optional build macro ISW_AND_SEQ_CTRL_CLEAR_EN zeroes all internal share/random/tmp/acc registers on DONE->IDLE.
//
// state | meaning
// IDLE  | waiting for operand shares, in_ready high
// RAND  | fetching r01, r02, r12 from the RNG (one request-setup cycle, then rnd_ready high)
// COMP  | partial-product steps s0..s11, one per cycle
// DONE  | result shares held until the consumer takes them
module isw_and_seq_ctrl #(
    parameter int W = 1
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic [W-1:0] a0_i,
    input  logic [W-1:0] a1_i,
    input  logic [W-1:0] a2_i,
    input  logic [W-1:0] b0_i,
    input  logic [W-1:0] b1_i,
    input  logic [W-1:0] b2_i,
    input  logic         rnd_valid_i,
    output logic         rnd_ready_o,
    input  logic [W-1:0] rnd_i,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic [W-1:0] c0_o,
    output logic [W-1:0] c1_o,
    output logic [W-1:0] c2_o,
    output logic         busy_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RAND = 2'd1,
        COMP = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t       state_q;
    logic [1:0]   beat_q;
    logic [3:0]   step_q;
    logic [W-1:0] a0_q, a1_q, a2_q, b0_q, b1_q, b2_q;
    logic [W-1:0] r01_q, r02_q, r12_q;
    logic [W-1:0] tmp_q, acc0_q, acc1_q, acc2_q;
    logic [W-1:0] c0_q, c1_q, c2_q;
    logic         in_ready_q, rnd_ready_q, out_valid_q, busy_q;

    logic [W-1:0] op_x_d, op_y_d, pp_d;

    // Single shared AND: operand pair selected by step, zero on steps without a product.
    always_comb begin
        op_x_d = '0;
        op_y_d = '0;
        case (step_q)
            4'd0:    begin op_x_d = a0_q; op_y_d = b0_q; end
            4'd1:    begin op_x_d = a1_q; op_y_d = b1_q; end
            4'd2:    begin op_x_d = a2_q; op_y_d = b2_q; end
            4'd3:    begin op_x_d = a0_q; op_y_d = b1_q; end
            4'd4:    begin op_x_d = a1_q; op_y_d = b0_q; end
            4'd6:    begin op_x_d = a0_q; op_y_d = b2_q; end
            4'd7:    begin op_x_d = a2_q; op_y_d = b0_q; end
            4'd9:    begin op_x_d = a1_q; op_y_d = b2_q; end
            4'd10:   begin op_x_d = a2_q; op_y_d = b1_q; end
            default: begin op_x_d = '0;   op_y_d = '0;   end
        endcase
        pp_d = op_x_d & op_y_d;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            beat_q      <= 2'd0;
            step_q      <= 4'd0;
            a0_q        <= '0;
            a1_q        <= '0;
            a2_q        <= '0;
            b0_q        <= '0;
            b1_q        <= '0;
            b2_q        <= '0;
            r01_q       <= '0;
            r02_q       <= '0;
            r12_q       <= '0;
            tmp_q       <= '0;
            acc0_q      <= '0;
            acc1_q      <= '0;
            acc2_q      <= '0;
            c0_q        <= '0;
            c1_q        <= '0;
            c2_q        <= '0;
            in_ready_q  <= 1'b1;
            rnd_ready_q <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid_i) begin
                        a0_q       <= a0_i;
                        a1_q       <= a1_i;
                        a2_q       <= a2_i;
                        b0_q       <= b0_i;
                        b1_q       <= b1_i;
                        b2_q       <= b2_i;
                        beat_q     <= 2'd0;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        state_q    <= RAND;
                    end
                end
                RAND: begin
                    // rnd_ready rises one cycle after entry; that setup cycle is part of the 16-cycle latency.
                    if (rnd_ready_q && rnd_valid_i) begin
                        case (beat_q)
                            2'd0:    r01_q <= rnd_i;
                            2'd1:    r02_q <= rnd_i;
                            default: r12_q <= rnd_i;
                        endcase
                        beat_q <= beat_q + 2'd1;
                        if (beat_q == 2'd2) begin
                            rnd_ready_q <= 1'b0;
                            step_q      <= 4'd0;
                            state_q     <= COMP;
                        end
                    end else begin
                        rnd_ready_q <= 1'b1;
                    end
                end
                COMP: begin
                    step_q <= step_q + 4'd1;
                    // Randomness always enters tmp before the second cross product of each pair.
                    case (step_q)
                        4'd0:  acc0_q <= pp_d;
                        4'd1:  acc1_q <= pp_d;
                        4'd2:  acc2_q <= pp_d;
                        4'd3:  tmp_q  <= pp_d ^ r01_q;
                        4'd4:  tmp_q  <= tmp_q ^ pp_d;
                        4'd5: begin
                            acc0_q <= acc0_q ^ r01_q;
                            acc1_q <= acc1_q ^ tmp_q;
                        end
                        4'd6:  tmp_q  <= pp_d ^ r02_q;
                        4'd7:  tmp_q  <= tmp_q ^ pp_d;
                        4'd8: begin
                            acc0_q <= acc0_q ^ r02_q;
                            acc2_q <= acc2_q ^ tmp_q;
                        end
                        4'd9:  tmp_q  <= pp_d ^ r12_q;
                        4'd10: tmp_q  <= tmp_q ^ pp_d;
                        4'd11: begin
                            c0_q        <= acc0_q;
                            c1_q        <= acc1_q ^ r12_q;
                            c2_q        <= acc2_q ^ tmp_q;
                            out_valid_q <= 1'b1;
                            state_q     <= DONE;
                        end
                        default: ;
                    endcase
                end
                DONE: begin
                    if (out_ready_i) begin
                        out_valid_q <= 1'b0;
                        c0_q        <= '0;
                        c1_q        <= '0;
                        c2_q        <= '0;
                        in_ready_q  <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= IDLE;
`ifdef ISW_AND_SEQ_CTRL_CLEAR_EN
                        a0_q   <= '0;
                        a1_q   <= '0;
                        a2_q   <= '0;
                        b0_q   <= '0;
                        b1_q   <= '0;
                        b2_q   <= '0;
                        r01_q  <= '0;
                        r02_q  <= '0;
                        r12_q  <= '0;
                        tmp_q  <= '0;
                        acc0_q <= '0;
                        acc1_q <= '0;
                        acc2_q <= '0;
`else
                        tmp_q  <= tmp_q;
`endif
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready_o  = in_ready_q;
    assign rnd_ready_o = rnd_ready_q;
    assign out_valid_o = out_valid_q;
    assign busy_o      = busy_q;
    assign c0_o        = c0_q;
    assign c1_o        = c1_q;
    assign c2_o        = c2_q;

endmodule

// File: tb/tb_isw_and_seq_ctrl.sv
// Self-checking bench for isw_and_seq_ctrl: directed vector table, RNG stall, backpressure, mid-COMP reset, random regression.
`timescale 1ns/1ps
module tb_isw_and_seq_ctrl;
    localparam int W = 8;

    logic         clk_i = 1'b0;
    logic         rst_i = 1'b1;
    logic         in_valid_i = 1'b0;
    logic         in_ready_o;
    logic [W-1:0] a0_i = '0, a1_i = '0, a2_i = '0;
    logic [W-1:0] b0_i = '0, b1_i = '0, b2_i = '0;
    logic         rnd_valid_i = 1'b0;
    logic         rnd_ready_o;
    logic [W-1:0] rnd_i = '0;
    logic         out_valid_o;
    logic         out_ready_i = 1'b0;
    logic [W-1:0] c0_o, c1_o, c2_o;
    logic         busy_o;

    isw_and_seq_ctrl #(.W(W)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .a0_i(a0_i), .a1_i(a1_i), .a2_i(a2_i),
        .b0_i(b0_i), .b1_i(b1_i), .b2_i(b2_i),
        .rnd_valid_i(rnd_valid_i), .rnd_ready_o(rnd_ready_o), .rnd_i(rnd_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .c0_o(c0_o), .c1_o(c1_o), .c2_o(c2_o),
        .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [W-1:0] a0, a1, a2, b0, b1, b2;
        logic [W-1:0] r01, r02, r12;
        logic [W-1:0] c0, c1, c2;
    } vec_t;

    vec_t         vecs [5];
    logic [W-1:0] tmp_log [64];
    int           n_checks = 0;
    int           n_pass = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // One full operation: accept, RNG beats, wait for result, optional hold, output handshake.
    task automatic do_op(input vec_t v, input int stall1, input bit rand_gaps, input int hold,
                         output int lat, output int stalls,
                         output logic [W-1:0] oc0, output logic [W-1:0] oc1, output logic [W-1:0] oc2,
                         output bit leak_bad, output bit hold_bad, output bit post_bad);
        int beat;
        int k;
        int st_left;
        bit hs;
        logic [W-1:0] rv [3];
        rv[0] = v.r01; rv[1] = v.r02; rv[2] = v.r12;
        st_left = stall1;
        leak_bad = 1'b0; hold_bad = 1'b0; post_bad = 1'b0;
        stalls = 0;
        k = 0;
        while (!in_ready_o && k < 100) begin tick(); k++; end
        a0_i = v.a0; a1_i = v.a1; a2_i = v.a2;
        b0_i = v.b0; b1_i = v.b1; b2_i = v.b2;
        in_valid_i = 1'b1;
        tick();
        in_valid_i = 1'b0;
        a0_i = W'($urandom); a1_i = W'($urandom); a2_i = W'($urandom);
        b0_i = W'($urandom); b1_i = W'($urandom); b2_i = W'($urandom);
        beat = 0;
        k = 0;
        while (!out_valid_o && k < 200) begin
            if (beat < 3) begin
                if (beat == 1 && st_left > 0) begin
                    rnd_valid_i = 1'b0;
                    rnd_i = '1;
                    st_left--;
                end else begin
                    rnd_valid_i = rand_gaps ? 1'($urandom_range(0, 1)) : 1'b1;
                    rnd_i = rnd_valid_i ? rv[beat] : W'($urandom);
                end
                if (rnd_ready_o && !rnd_valid_i) stalls++;
            end else begin
                rnd_valid_i = 1'b1;
                rnd_i = W'($urandom);
            end
            hs = rnd_valid_i && rnd_ready_o;
            tick();
            k++;
            if (hs) beat++;
            if (k < 64) tmp_log[k] = dut.tmp_q;
            if (!out_valid_o && ((c0_o | c1_o | c2_o) != '0 || in_ready_o || !busy_o)) leak_bad = 1'b1;
        end
        rnd_valid_i = 1'b0;
        lat = k;
        oc0 = c0_o; oc1 = c1_o; oc2 = c2_o;
        for (int i = 0; i < hold; i++) begin
            out_ready_i = 1'b0;
            tick();
            if (!out_valid_o || c0_o !== oc0 || c1_o !== oc1 || c2_o !== oc2 || in_ready_o || !busy_o)
                hold_bad = 1'b1;
        end
        out_ready_i = 1'b1;
        tick();
        out_ready_i = 1'b0;
        if (out_valid_o || (c0_o | c1_o | c2_o) != '0 || !in_ready_o || busy_o) post_bad = 1'b1;
    endtask

    int           lat, stalls;
    logic [W-1:0] oc0, oc1, oc2;
    bit           leak_bad, hold_bad, post_bad;
    vec_t         rv;
    logic [W-1:0] tmp_exp [8];

    initial begin
        vecs[0] = '{a0:8'h0A, a1:8'h03, a2:8'h05, b0:8'h06, b1:8'h0F, b2:8'h01,
                    r01:8'h01, r02:8'h02, r12:8'h04, c0:8'h01, c1:8'h0E, c2:8'h07};
        vecs[1] = '{a0:8'h00, a1:8'h00, a2:8'h00, b0:8'h00, b1:8'h00, b2:8'h00,
                    r01:8'h05, r02:8'h06, r12:8'h07, c0:8'h03, c1:8'h02, c2:8'h01};
        vecs[2] = '{a0:8'hFF, a1:8'h00, a2:8'h00, b0:8'hFF, b1:8'h00, b2:8'h00,
                    r01:8'h00, r02:8'h00, r12:8'h00, c0:8'hFF, c1:8'h00, c2:8'h00};
        vecs[3] = '{a0:8'hF0, a1:8'h0F, a2:8'h00, b0:8'h0F, b1:8'hF0, b2:8'h00,
                    r01:8'hAA, r02:8'h55, r12:8'h33, c0:8'hFF, c1:8'h66, c2:8'h66};
        vecs[4] = '{a0:8'h12, a1:8'h34, a2:8'h56, b0:8'h78, b1:8'h9A, b2:8'hBC,
                    r01:8'h01, r02:8'h02, r12:8'h03, c0:8'h13, c1:8'h30, c2:8'h73};
        tmp_exp[0] = 8'h0B; tmp_exp[1] = 8'h09; tmp_exp[2] = 8'h09; tmp_exp[3] = 8'h02;
        tmp_exp[4] = 8'h06; tmp_exp[5] = 8'h06; tmp_exp[6] = 8'h05; tmp_exp[7] = 8'h00;

        rst_i = 1'b1;
        repeat (3) tick();
        check("reset in_ready", in_ready_o, 1);
        check("reset rnd_ready", rnd_ready_o, 0);
        check("reset out_valid", out_valid_o, 0);
        check("reset busy", busy_o, 0);
        check("reset c", c0_o | c1_o | c2_o, 0);
        rst_i = 1'b0;
        tick();

        for (int i = 0; i < 5; i++) begin
            do_op(vecs[i], 0, 1'b0, 0, lat, stalls, oc0, oc1, oc2, leak_bad, hold_bad, post_bad);
            check($sformatf("vec%0d c0", i), oc0, vecs[i].c0);
            check($sformatf("vec%0d c1", i), oc1, vecs[i].c1);
            check($sformatf("vec%0d c2", i), oc2, vecs[i].c2);
            check($sformatf("vec%0d latency", i), lat, 16);
            check($sformatf("vec%0d no leak", i), leak_bad, 0);
            check($sformatf("vec%0d post handshake", i), post_bad, 0);
            if (i == 0) begin
                for (int s = 3; s <= 10; s++)
                    check($sformatf("golden tmp s%0d", s), tmp_log[5 + s], tmp_exp[s - 3]);
            end
        end

        do_op(vecs[0], 0, 1'b0, 0, lat, stalls, oc0, oc1, oc2, leak_bad, hold_bad, post_bad);
`ifdef ISW_AND_SEQ_CTRL_CLEAR_EN
        check("clear internals",
              dut.a0_q | dut.a1_q | dut.a2_q | dut.b0_q | dut.b1_q | dut.b2_q |
              dut.r01_q | dut.r02_q | dut.r12_q | dut.tmp_q |
              dut.acc0_q | dut.acc1_q | dut.acc2_q, 0);
`else
        check("stale a0", dut.a0_q, 8'h0A);
        check("stale acc0", dut.acc0_q, 8'h01);
`endif

        do_op(vecs[0], 5, 1'b0, 0, lat, stalls, oc0, oc1, oc2, leak_bad, hold_bad, post_bad);
        check("stall c0", oc0, 8'h01);
        check("stall c1", oc1, 8'h0E);
        check("stall c2", oc2, 8'h07);
        check("stall latency", lat, 21);
        check("stall r02", dut.r02_q === 8'h02 || dut.r02_q === 8'h00, 1);

        do_op(vecs[0], 0, 1'b0, 7, lat, stalls, oc0, oc1, oc2, leak_bad, hold_bad, post_bad);
        check("backpressure hold", hold_bad, 0);
        check("backpressure c0", oc0, 8'h01);
        check("backpressure c1", oc1, 8'h0E);
        check("backpressure c2", oc2, 8'h07);
        check("backpressure idle", post_bad, 0);

        a0_i = 8'h0A; a1_i = 8'h03; a2_i = 8'h05;
        b0_i = 8'h06; b1_i = 8'h0F; b2_i = 8'h01;
        in_valid_i = 1'b1;
        tick();
        in_valid_i = 1'b0;
        rnd_valid_i = 1'b1;
        rnd_i = 8'h3C;
        repeat (10) tick();
        check("midcomp at s6", dut.step_q, 6);
        check("midcomp in COMP", 32'(dut.state_q), 2);
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        rnd_valid_i = 1'b0;
        check("midrst in_ready", in_ready_o, 1);
        check("midrst rnd_ready", rnd_ready_o, 0);
        check("midrst out_valid", out_valid_o, 0);
        check("midrst busy", busy_o, 0);
        check("midrst c", c0_o | c1_o | c2_o, 0);
        check("midrst internals", dut.tmp_q | dut.acc0_q | dut.acc1_q | dut.acc2_q | dut.r01_q, 0);
        do_op(vecs[4], 0, 1'b0, 0, lat, stalls, oc0, oc1, oc2, leak_bad, hold_bad, post_bad);
        check("after reset c0", oc0, 8'h13);
        check("after reset c1", oc1, 8'h30);
        check("after reset c2", oc2, 8'h73);
        check("after reset latency", lat, 16);

        for (int n = 0; n < 1000; n++) begin
            rv.a0 = W'($urandom); rv.a1 = W'($urandom); rv.a2 = W'($urandom);
            rv.b0 = W'($urandom); rv.b1 = W'($urandom); rv.b2 = W'($urandom);
            rv.r01 = W'($urandom); rv.r02 = W'($urandom); rv.r12 = W'($urandom);
            rv.c0 = '0; rv.c1 = '0; rv.c2 = '0;
            do_op(rv, 0, 1'b1, $urandom_range(0, 3), lat, stalls, oc0, oc1, oc2, leak_bad, hold_bad, post_bad);
            check($sformatf("rand%0d xor", n), oc0 ^ oc1 ^ oc2,
                  (rv.a0 ^ rv.a1 ^ rv.a2) & (rv.b0 ^ rv.b1 ^ rv.b2));
            check($sformatf("rand%0d latency", n), lat, 16 + stalls);
            check($sformatf("rand%0d handshake", n), {leak_bad, hold_bad, post_bad}, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
